// File: rtl/lcd_pixel_fifo.sv
// lcd_pixel_fifo: RGB565 pixel-to-byte FWFT buffer feeding the lcd_ctrl read port.
module lcd_pixel_fifo #(
    parameter int DEPTH    = 512,
    parameter int ADDR_W   = 9,
    parameter int AFULL_TH = 480
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              pix_valid,
    input  logic [15:0]       pix_data,
    output logic              pix_ready,
    input  logic              fifo_rd_en,
    output logic [7:0]        fifo_rd_data,
    output logic              fifo_empty,
    output logic [ADDR_W:0]   level,
    output logic              almost_full,
    output logic              underflow
);
    localparam logic [ADDR_W:0]   LVL_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   LVL_TWO   = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0]   READY_MAX = (ADDR_W+1)'(DEPTH - 2);
    localparam logic [ADDR_W:0]   AFULL_LVL = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_TWO   = ADDR_W'(2);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              underflow_q, underflow_d;
    logic              push, pop;

    assign pix_ready    = level_q <= READY_MAX;
    assign fifo_empty   = level_q == '0;
    assign almost_full  = level_q >= AFULL_LVL;
    assign level        = level_q;
    assign underflow    = underflow_q;
    assign fifo_rd_data = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign push         = pix_valid && pix_ready;
    assign pop          = fifo_rd_en && !fifo_empty;

    always_comb begin
        wr_ptr_d    = clr ? '0 : wr_ptr_q + (push ? PTR_TWO : '0);
        rd_ptr_d    = clr ? '0 : rd_ptr_q + (pop ? PTR_ONE : '0);
        level_d     = clr ? '0 : level_q + (push ? LVL_TWO : '0) - (pop ? LVL_ONE : '0);
        underflow_d = !clr && (underflow_q || (fifo_rd_en && fifo_empty));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            underflow_q <= underflow_d;
        end
    end

    // wr_ptr is always even, so the pixel's two bytes never straddle the wrap
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_q[wr_ptr_q]           <= pix_data[15:8];
            mem_q[wr_ptr_q | PTR_ONE] <= pix_data[7:0];
        end
    end
endmodule
